// File: rtl/rd_port_arbiter.sv
// Round-robin read-port scheduler for the async FIFO. A grant covers one burst of up to MAX_BURST beats.
// Returned words appear 1 cycle after fifo_rd_en, tagged one-hot to their owner. An empty FIFO stalls the grant with no read.
module rd_port_arbiter #(
   parameter int DATA_SIZE = 8,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                 rd_clk,
   input  logic                 rd_rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic                 fifo_rd_empty,
   input  logic [DATA_SIZE-1:0] fifo_rd_data,
   output logic                 fifo_rd_en,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   rd_valid,
   output logic [DATA_SIZE-1:0] rd_data_out,
   output logic [3:0]           beat_cnt
);

   localparam int                 IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [3:0]         BURST_MAX = 4'(MAX_BURST);
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   rr_last;
   logic [IDX_W-1:0]   rr_last_nxt;
   logic [IDX_W-1:0]   winner;
   logic               found;
   int                 scan_idx;
   logic [NUM_REQ-1:0] gnt_nxt;
   logic [3:0]         beat_nxt;
   logic               owner_req;

   // Scan starts just after the previous winner so a held request waits at most NUM_REQ-1 bursts.
   always_comb begin
      winner   = rr_last;
      found    = 1'b0;
      scan_idx = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         scan_idx = int'(rr_last) + i;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         if (!found && req[IDX_W'(scan_idx)]) begin
            winner = IDX_W'(scan_idx);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      rr_last_nxt = rr_last;
      beat_nxt    = beat_cnt;
      fifo_rd_en  = 1'b0;
      owner_req   = |(req & gnt);
      case (state)
         IDLE: begin
            if (found) begin
               gnt_nxt     = ONE_HOT0 << winner;
               rr_last_nxt = winner;
               beat_nxt    = '0;
               state_nxt   = BURST;
            end
         end
         BURST: begin
            fifo_rd_en = rd_rst_n & owner_req & ~fifo_rd_empty & (beat_cnt < BURST_MAX);
            beat_nxt   = beat_cnt + 4'(fifo_rd_en);
            // beat_cnt keeps its final value through IDLE until the next grant clears it.
            if (!owner_req || (beat_nxt == BURST_MAX)) begin
               gnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         state       <= IDLE;
         gnt         <= '0;
         rr_last     <= LAST_IDX;
         beat_cnt    <= '0;
         rd_valid    <= '0;
         rd_data_out <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         rr_last  <= rr_last_nxt;
         beat_cnt <= beat_nxt;
         rd_valid <= fifo_rd_en ? gnt : '0;
         if (fifo_rd_en) begin
            rd_data_out <= fifo_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Directed and randomised checks of rd_port_arbiter against a behavioural FWFT FIFO.
module tb_rd_port_arbiter;

   logic       rd_clk = 1'b0;
   logic       rd_rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic       fifo_rd_empty;
   logic [7:0] fifo_rd_data;
   logic       fifo_rd_en;
   logic [3:0] gnt;
   logic [3:0] rd_valid;
   logic [7:0] rd_data_out;
   logic [3:0] beat_cnt;

   logic [7:0] mem [0:4095];
   int         wp = 0;
   int         rp = 0;
   logic       flush = 1'b0;

   int         n_cmp = 0;
   int         n_err = 0;

   int         deliv = 0;
   int         cnt = 0;
   logic       prev_en = 1'b0;
   logic [3:0] prev_gnt = 4'b0000;

   rd_port_arbiter #(
      .DATA_SIZE(8),
      .NUM_REQ  (4),
      .MAX_BURST(4)
   ) dut (
      .rd_clk       (rd_clk),
      .rd_rst_n     (rd_rst_n),
      .req          (req),
      .fifo_rd_empty(fifo_rd_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .gnt          (gnt),
      .rd_valid     (rd_valid),
      .rd_data_out  (rd_data_out),
      .beat_cnt     (beat_cnt)
   );

   always #5 rd_clk = ~rd_clk;

   assign fifo_rd_empty = (wp == rp);
   assign fifo_rd_data  = mem[rp[11:0]];

   always @(posedge rd_clk) begin
      if (flush) rp <= wp;
      else if (fifo_rd_en) rp <= rp + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(negedge rd_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      mem[wp[11:0]] = d;
      wp = wp + 1;
   endtask

   task automatic reset_dut();
      req      = 4'b0000;
      rd_rst_n = 1'b0;
      tick();
      tick();
      rd_rst_n = 1'b1;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
   endtask

   task automatic t6_cycle(input logic [3:0] r, input bit do_push);
      check_val("t6_tag", {28'd0, rd_valid}, prev_en ? {28'd0, prev_gnt} : 32'd0);
      if (prev_en) begin
         check_val("t6_data", {24'd0, rd_data_out}, {24'd0, mem[deliv[11:0]]});
         deliv++;
      end
      check_val("t6_gnt_1hot", {31'd0, $onehot0(gnt)}, 32'd1);
      if (gnt == 4'b0000) cnt = 0;
      else check_val("t6_beat", {28'd0, beat_cnt}, cnt);
      req = r;
      if (do_push) push(8'($urandom));
      #1;
      check_val("t6_no_rd_empty", {31'd0, fifo_rd_en & fifo_rd_empty}, 32'd0);
      check_val("t6_rd_owner", {31'd0, fifo_rd_en & (gnt == 4'b0000)}, 32'd0);
      if (fifo_rd_en) begin
         cnt++;
         check_val("t6_burst_max", {31'd0, cnt <= 4}, 32'd1);
      end
      prev_en  = fifo_rd_en;
      prev_gnt = gnt;
      tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [3:0] r;
      // Reset state
      reset_dut();
      check_val("rst_gnt", {28'd0, gnt}, 32'd0);
      check_val("rst_valid", {28'd0, rd_valid}, 32'd0);
      check_val("rst_data", {24'd0, rd_data_out}, 32'd0);
      check_val("rst_beat", {28'd0, beat_cnt}, 32'd0);
      check_val("rst_en", {31'd0, fifo_rd_en}, 32'd0);

      // T1: reset mid-burst with FIFO non-empty
      for (int k = 0; k < 10; k++) push(8'hC0 + 8'(k));
      req = 4'b0001;
      tick();
      tick();
      check_val("t1_en_before", {31'd0, fifo_rd_en}, 32'd1);
      rd_rst_n = 1'b0;
      #1;
      check_val("t1_en_gated", {31'd0, fifo_rd_en}, 32'd0);
      tick();
      check_val("t1_gnt", {28'd0, gnt}, 32'd0);
      check_val("t1_valid", {28'd0, rd_valid}, 32'd0);
      check_val("t1_beat", {28'd0, beat_cnt}, 32'd0);

      // T2: single requester, one capped burst then re-grant
      reset_dut();
      for (int k = 0; k < 10; k++) push(8'hA0 + 8'(k));
      req = 4'b0001;
      #1;
      check_val("t2_idle_en", {31'd0, fifo_rd_en}, 32'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         check_val("t2_gnt", {28'd0, gnt}, 32'd1);
         check_val("t2_beat", {28'd0, beat_cnt}, k);
         check_val("t2_en", {31'd0, fifo_rd_en}, 32'd1);
         if (k > 0) begin
            check_val("t2_valid", {28'd0, rd_valid}, 32'd1);
            check_val("t2_data", {24'd0, rd_data_out}, 32'hA0 + k - 1);
         end
         tick();
      end
      check_val("t2_bubble_gnt", {28'd0, gnt}, 32'd0);
      check_val("t2_last_valid", {28'd0, rd_valid}, 32'd1);
      check_val("t2_last_data", {24'd0, rd_data_out}, 32'hA3);
      check_val("t2_bubble_en", {31'd0, fifo_rd_en}, 32'd0);
      check_val("t2_bubble_beat", {28'd0, beat_cnt}, 32'd4);
      tick();
      check_val("t2_regrant", {28'd0, gnt}, 32'd1);
      check_val("t2_regrant_valid", {28'd0, rd_valid}, 32'd0);
      check_val("t2_regrant_beat", {28'd0, beat_cnt}, 32'd0);
      check_val("t2_data_hold", {24'd0, rd_data_out}, 32'hA3);

      // T3: all requesting, round-robin with one bubble per switch
      reset_dut();
      for (int k = 0; k < 40; k++) push(8'(k));
      req = 4'b1111;
      tick();
      for (int b = 0; b < 5; b++) begin
         check_val("t3_gnt", {28'd0, gnt}, 32'd1 << (b % 4));
         n = 0;
         for (int c = 0; c < 4; c++) begin
            n += int'(fifo_rd_en);
            tick();
         end
         check_val("t3_beats", n, 32'd4);
         check_val("t3_bubble", {28'd0, gnt}, 32'd0);
         tick();
      end

      // T4: empty FIFO stalls the grant
      reset_dut();
      push(8'hB0);
      push(8'hB1);
      req = 4'b0010;
      tick();
      check_val("t4_gnt", {28'd0, gnt}, 32'd2);
      check_val("t4_en0", {31'd0, fifo_rd_en}, 32'd1);
      tick();
      check_val("t4_en1", {31'd0, fifo_rd_en}, 32'd1);
      check_val("t4_beat1", {28'd0, beat_cnt}, 32'd1);
      tick();
      check_val("t4_stall_en", {31'd0, fifo_rd_en}, 32'd0);
      check_val("t4_stall_gnt", {28'd0, gnt}, 32'd2);
      check_val("t4_beat2", {28'd0, beat_cnt}, 32'd2);
      check_val("t4_valid1", {28'd0, rd_valid}, 32'd2);
      check_val("t4_data1", {24'd0, rd_data_out}, 32'hB1);
      tick();
      tick();
      check_val("t4_hold_gnt", {28'd0, gnt}, 32'd2);
      check_val("t4_hold_en", {31'd0, fifo_rd_en}, 32'd0);
      check_val("t4_hold_valid", {28'd0, rd_valid}, 32'd0);
      push(8'hB2);
      #1;
      check_val("t4_resume_en", {31'd0, fifo_rd_en}, 32'd1);
      tick();
      check_val("t4_beat3", {28'd0, beat_cnt}, 32'd3);
      check_val("t4_gnt3", {28'd0, gnt}, 32'd2);
      check_val("t4_valid3", {28'd0, rd_valid}, 32'd2);
      check_val("t4_data3", {24'd0, rd_data_out}, 32'hB2);

      // T5: owner releases early, next requester follows after the bubble
      reset_dut();
      for (int k = 0; k < 10; k++) push(8'hD0 + 8'(k));
      req = 4'b1100;
      tick();
      check_val("t5_gnt", {28'd0, gnt}, 32'd4);
      check_val("t5_en0", {31'd0, fifo_rd_en}, 32'd1);
      tick();
      check_val("t5_en1", {31'd0, fifo_rd_en}, 32'd1);
      tick();
      check_val("t5_last_tag", {28'd0, rd_valid}, 32'd4);
      check_val("t5_last_data", {24'd0, rd_data_out}, 32'hD1);
      req = 4'b1000;
      #1;
      check_val("t5_drop_en", {31'd0, fifo_rd_en}, 32'd0);
      tick();
      check_val("t5_idle_gnt", {28'd0, gnt}, 32'd0);
      check_val("t5_final_beat", {28'd0, beat_cnt}, 32'd2);
      check_val("t5_idle_valid", {28'd0, rd_valid}, 32'd0);
      tick();
      check_val("t5_next_gnt", {28'd0, gnt}, 32'd8);

      // T6: random requests and pushes against an in-order scoreboard
      reset_dut();
      deliv    = wp;
      cnt      = 0;
      prev_en  = 1'b0;
      prev_gnt = 4'b0000;
      r        = 4'b0000;
      for (int c = 0; c < 10000; c++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         t6_cycle(r, ($urandom_range(0, 9) < 4) && ((wp - rp) < 1000));
      end
      for (int c = 0; c < 3000 && deliv != wp; c++) begin
         t6_cycle(4'b1111, 1'b0);
      end
      check_val("t6_drain", deliv, wp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
